// File: rtl/gates_arb_pkg.sv
// Shared types and constants for the round-robin gate-unit arbiter.
// Result bit positions of the gate unit and the arbiter FSM state encoding.
package gates_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_e;

    localparam int Y_W   = 3;
    localparam int Y_AND = 2;
    localparam int Y_OR  = 1;
    localparam int Y_NOT = 0;

endpackage

// File: rtl/gates.sv
// Combinational logic-gate unit: y = {a&b, a|b, ~a}.
// Zero latency, no flow control.
module gates
    import gates_arb_pkg::*;
(
    input  logic           a_i,
    input  logic           b_i,
    output logic [Y_W-1:0] y_o
);

    always_comb begin
        y_o        = '0;
        y_o[Y_AND] = a_i & b_i;
        y_o[Y_OR]  = a_i | b_i;
        y_o[Y_NOT] = ~a_i;
    end

endmodule

// File: rtl/gates_rr_arbiter.sv
// Round-robin sharing of one gate unit among NREQ requesters; req->gnt 1 cycle, req->resp 2 cycles.
// One operation in flight; a stalled response holds the unit and blocks further grants.
module gates_rr_arbiter
    import gates_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ),
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] req_a,
    input  logic [NREQ-1:0] req_b,
    output logic [NREQ-1:0] gnt,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [IDW-1:0]  resp_id,
    output logic [Y_W-1:0]  resp_y,
    output logic            busy,
    output logic [CNTW-1:0] op_count
);

    arb_state_e      state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic            a_q, a_d;
    logic            b_q, b_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            vld_q, vld_d;
    logic [Y_W-1:0]  y_q, y_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [Y_W-1:0]  gates_y;
    logic [IDW-1:0]  winner;

    // Search ptr+1, ptr+2, ... wrapping; later loop iterations are nearer to ptr+1 and win.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [IDW-1:0]  p);
        logic [IDW-1:0] win;
        int             idx;
        win = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(p) + k) % NREQ;
            if (r[IDW'(idx)]) win = IDW'(idx);
        end
        return win;
    endfunction

    gates u_gates (
        .a_i (a_q),
        .b_i (b_q),
        .y_o (gates_y)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        gnt_d   = '0;
        vld_d   = vld_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        winner  = rr_pick(req, ptr_q);

        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    id_d    = winner;
                    a_d     = req_a[winner];
                    b_d     = req_b[winner];
                    gnt_d   = NREQ'(1) << winner;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                y_d     = gates_y;
                vld_d   = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (vld_q && resp_ready) begin
                    vld_d   = 1'b0;
                    ptr_d   = id_q;
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= IDW'(NREQ - 1);
            id_q    <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            gnt_q   <= '0;
            vld_q   <= 1'b0;
            y_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            gnt_q   <= gnt_d;
            vld_q   <= vld_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt        = gnt_q;
    assign resp_valid = vld_q;
    assign resp_id    = id_q;
    assign resp_y     = y_q;
    assign busy       = (state_q != IDLE);
    assign op_count   = cnt_q;

endmodule

// File: tb/tb_gates_rr_arbiter.sv
// Bench for gates_rr_arbiter: directed scenarios plus a randomized run against an operation-level model.
module tb_gates_rr_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int CNTW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req, req_a, req_b;
    logic [NREQ-1:0] gnt;
    logic            resp_valid, resp_ready;
    logic [IDW-1:0]  resp_id;
    logic [2:0]      resp_y;
    logic            busy;
    logic [CNTW-1:0] op_count;

    int n_vec = 0;
    int n_err = 0;

    // Model: progress of the single in-flight operation (0 free, 1 granted, 2 result waiting).
    int         m_phase, m_ptr, m_id, m_cnt;
    bit         m_a, m_b, m_vld;
    logic [3:0] m_gnt;
    logic [2:0] m_y;

    gates_rr_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_a      (req_a),
        .req_b      (req_b),
        .gnt        (gnt),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_y     (resp_y),
        .busy       (busy),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] gate_ref(input bit a, input bit b);
        int and_v, or_v, not_v;
        and_v = int'(a) * int'(b);
        or_v  = (int'(a) + int'(b) > 0) ? 1 : 0;
        not_v = 1 - int'(a);
        return 3'(and_v * 4 + or_v * 2 + not_v);
    endfunction

    task automatic model_edge();
        int w;
        if (rst) begin
            m_phase = 0; m_ptr = NREQ - 1; m_id = 0; m_cnt = 0;
            m_vld = 0; m_gnt = '0; m_y = '0;
            return;
        end
        m_gnt = '0;
        case (m_phase)
            0: if (req != '0) begin
                w = -1;
                for (int k = 1; k <= NREQ; k++)
                    if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
                m_id = w; m_a = req_a[w]; m_b = req_b[w];
                m_gnt[w] = 1'b1;
                m_phase = 1;
            end
            1: begin
                m_y = gate_ref(m_a, m_b); m_vld = 1; m_phase = 2;
            end
            default: if (resp_ready) begin
                m_vld = 0; m_ptr = m_id;
                if (m_cnt < 65535) m_cnt++;
                m_phase = 0;
            end
        endcase
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; resp_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; req_a = '0; req_b = '0; resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (gnt !== 4'b0000 || resp_valid !== 1'b0 || busy !== 1'b0 || op_count !== 16'd0) begin
                n_err++;
                $display("FAIL reset_hold cyc%0d: gnt=%b vld=%b busy=%b cnt=%0d, want 0000 0 0 0",
                         i, gnt, resp_valid, busy, op_count);
            end
        end
        rst = 1'b0;
        tick();
        n_vec++;
        if (gnt !== 4'b0001) begin
            n_err++;
            $display("FAIL reset_first_gnt: gnt=%b, want 0001", gnt);
        end
        req = '0;
        tick(); tick();
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001; req_a = 4'b0001; req_b = 4'b0001; resp_ready = 1'b1;
        tick();
        n_vec++;
        if (gnt !== 4'b0001 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_gnt: gnt=%b busy=%b, want 0001 1", gnt, busy);
        end
        req = '0;
        tick();
        n_vec++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_y !== 3'b110 || gnt !== 4'b0000) begin
            n_err++;
            $display("FAIL single_resp: vld=%b id=%0d y=%b gnt=%b, want 1 0 110 0000",
                     resp_valid, resp_id, resp_y, gnt);
        end
        tick();
        n_vec++;
        if (resp_valid !== 1'b0 || op_count !== 16'd1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_done: vld=%b cnt=%0d busy=%b, want 0 1 0", resp_valid, op_count, busy);
        end
    endtask

    task automatic test_truth_table();
        logic [2:0] exp_y [4];
        exp_y[0] = 3'b001; exp_y[1] = 3'b011; exp_y[2] = 3'b010; exp_y[3] = 3'b110;
        resp_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            req = 4'b0100;
            req_a = '0; req_b = '0;
            req_a[2] = v[1]; req_b[2] = v[0];
            tick();
            n_vec++;
            if (gnt !== 4'b0100) begin
                n_err++;
                $display("FAIL truth_gnt ab=%0d: gnt=%b, want 0100", v, gnt);
            end
            req = '0; req_a = ~req_a; req_b = ~req_b;
            tick();
            n_vec++;
            if (resp_y !== exp_y[v] || resp_id !== 2'd2 || resp_valid !== 1'b1) begin
                n_err++;
                $display("FAIL truth_y ab=%0d: y=%b id=%0d vld=%b, want %b 2 1",
                         v, resp_y, resp_id, resp_valid, exp_y[v]);
            end
            tick();
        end
    endtask

    task automatic test_fairness();
        int ops, t, last_g;
        do_reset();
        req = 4'b1111; req_a = $urandom; req_b = $urandom; resp_ready = 1'b1;
        ops = 0; t = 0; last_g = -100;
        while (ops < 8 && t < 200) begin
            tick();
            t++;
            if (gnt !== 4'b0000) begin
                n_vec++;
                if (t - last_g < 3) begin
                    n_err++;
                    $display("FAIL fair_gap: grants %0d cycles apart, want >=3", t - last_g);
                end
                last_g = t;
            end
            if (resp_valid === 1'b1) begin
                n_vec++;
                if (resp_id !== 2'(ops % 4)) begin
                    n_err++;
                    $display("FAIL fair_order op%0d: id=%0d, want %0d", ops, resp_id, ops % 4);
                end
                ops++;
            end
        end
        if (ops < 8) begin
            n_vec++; n_err++;
            $display("FAIL fair_timeout: %0d ops seen, want 8", ops);
        end
        req = '0;
        tick(); tick(); tick();
    endtask

    task automatic test_backpressure();
        logic [2:0] y0;
        do_reset();
        req = 4'b0001; req_a = 4'b0000; req_b = 4'b0001; resp_ready = 1'b0;
        tick();
        req = 4'b0010;
        tick();
        y0 = 3'b011;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++;
            if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_y !== y0 || gnt !== 4'b0000) begin
                n_err++;
                $display("FAIL bp_hold cyc%0d: vld=%b id=%0d y=%b gnt=%b, want 1 0 %b 0000",
                         i, resp_valid, resp_id, resp_y, gnt, y0);
            end
        end
        resp_ready = 1'b1;
        tick();
        n_vec++;
        if (resp_valid !== 1'b0 || gnt !== 4'b0000 || op_count !== 16'd1) begin
            n_err++;
            $display("FAIL bp_handshake: vld=%b gnt=%b cnt=%0d, want 0 0000 1", resp_valid, gnt, op_count);
        end
        tick();
        n_vec++;
        if (gnt !== 4'b0010) begin
            n_err++;
            $display("FAIL bp_next_gnt: gnt=%b, want 0010", gnt);
        end
        req = '0;
        tick(); tick();
    endtask

    task automatic test_reset_mid_resp();
        do_reset();
        req = 4'b0010; req_a = 4'b0010; req_b = 4'b0010; resp_ready = 1'b0;
        tick();
        req = '0;
        tick(); tick();
        rst = 1'b1;
        tick();
        n_vec++;
        if (resp_valid !== 1'b0 || op_count !== 16'd0 || busy !== 1'b0 || resp_id !== 2'd0 || resp_y !== 3'd0) begin
            n_err++;
            $display("FAIL midresp_reset: vld=%b cnt=%0d busy=%b id=%0d y=%b, want 0 0 0 0 000",
                     resp_valid, op_count, busy, resp_id, resp_y);
        end
        rst = 1'b0; req = 4'b1111; resp_ready = 1'b1;
        tick();
        n_vec++;
        if (gnt !== 4'b0001) begin
            n_err++;
            $display("FAIL midresp_restart: gnt=%b, want 0001", gnt);
        end
        req = '0;
        tick(); tick();
        n_vec++;
        if (op_count !== 16'd1) begin
            n_err++;
            $display("FAIL midresp_count: cnt=%0d, want 1", op_count);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 249) == 0);
            req        = 4'($urandom);
            req_a      = 4'($urandom);
            req_b      = 4'($urandom);
            resp_ready = ($urandom_range(0, 2) != 0);
            tick();
            n_vec++;
            if (gnt !== m_gnt || resp_valid !== m_vld || busy !== (m_phase != 0) ||
                op_count !== 16'(m_cnt) ||
                (m_vld && (resp_id !== 2'(m_id) || resp_y !== m_y))) begin
                n_err++;
                $display("FAIL random cyc%0d: gnt=%b vld=%b id=%0d y=%b busy=%b cnt=%0d, want %b %b %0d %b %0d %0d",
                         c, gnt, resp_valid, resp_id, resp_y, busy, op_count,
                         m_gnt, m_vld, m_id, m_y, (m_phase != 0), m_cnt);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
        m_phase = 0; m_ptr = NREQ - 1; m_id = 0; m_cnt = 0; m_a = 0; m_b = 0;
        m_vld = 0; m_gnt = '0; m_y = '0;
        test_reset();
        test_single();
        test_truth_table();
        test_fairness();
        test_backpressure();
        test_reset_mid_resp();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
